lcd_irb_capture: RTL and testbench
==================================

// Module: lcd_irb_capture
// PURPOSE
//   Downstream stage of the LCD controller: models the image result buffer (IRB).
//   - Captures the 64 pixel writes the controller issues during its write-back (IRB_RW=0, IRB_A, IRB_D).
//   - Once the controller raises done, replays the stored 8x8 frame in raster order to a
//     panel/scoreboard port using a valid/ready handshake.
//   - Flags incomplete, duplicate and late writes.
// PARAMETERS
//   PIX_W   8   pixel width
//   ADDR_W  6   IRB address width; DEPTH = 2**ADDR_W = 64; row/col = ADDR_W/2 = 3 bits each
// PORTS
//   clk        in   1       rising-edge clock, shared with the controller
//   reset      in   1       asynchronous, active-low reset (0 = reset)
//   IRB_RW     in   1       0 = write strobe this cycle; 1 or X = no write
//   IRB_A      in   ADDR_W  write address
//   IRB_D      in   PIX_W   write data
//   done       in   1       controller write-back complete; level, sampled each edge
//   pix_valid  out  1       replay pixel valid
//   pix_ready  in   1       replay consumer ready
//   pix_data   out  PIX_W   replay pixel value
//   pix_x      out  3       column of pix_data (IRB_A[2:0])
//   pix_y      out  3       row of pix_data (IRB_A[5:3])
//   frame_end  out  1       high with the pixel at address 63
//   scan_done  out  1       sticky; set after the last replay handshake
//   wr_cnt     out  7       number of distinct addresses written (0..64)
//   err_dup    out  1       sticky; an address was written twice in CAPTURE
//   err_inc    out  1       sticky; done seen while wr_cnt < 64
//   err_late   out  1       sticky; write strobe seen outside CAPTURE
//   cksum      out  16      replay checksum; see CONFIGURATION
// BEHAVIOUR
//   Reset (reset=0, asynchronous):
//   - state=CAPTURE; all memory words, the 64-bit written bitmap, wr_cnt and scan pointer = 0.
//   - pix_valid, frame_end, scan_done, err_* = 0; pix_data, pix_x, pix_y, cksum = 0.
//   - Reset asserted mid-scan aborts the scan immediately; no partial state is kept.
//   CAPTURE:
//   - Each edge with IRB_RW==1'b0: mem[IRB_A] <= IRB_D; written-bit <= 1.
//   - If the address was not yet written, wr_cnt += 1; otherwise err_dup <= 1, the data still overwrites.
//   - done==1 at an edge: state <= SCAN, ptr <= 0. If wr_cnt < 64, also err_inc <= 1.
//   - A write and done on the same edge: the write is committed and counted before the wr_cnt check.
//   SCAN:
//   - pix_valid rises the edge after entry (1-cycle latency from done).
//   - pix_data = written[ptr] ? mem[ptr] : 0; pix_x = ptr[2:0], pix_y = ptr[5:3]; frame_end = (ptr==63).
//   - While pix_valid && !pix_ready, all pix_* and frame_end hold stable.
//   - On pix_valid && pix_ready: ptr += 1 and the next pixel is presented on the following cycle.
//     No bubble between pixels when pix_ready is held high: 64 pixels in 64 consecutive cycles.
//   - Handshake with ptr==63: pix_valid <= 0, frame_end <= 0, scan_done <= 1, state <= HOLD.
//   - Any IRB_RW==0 here: err_late <= 1; memory and wr_cnt are unchanged.
//   HOLD:
//   - Terminal state; outputs frozen and done ignored.
//   - Writes set err_late. Only reset leaves HOLD.
//   Widths:
//   - wr_cnt saturates at 64 by construction (bitmap).
//   - ptr is ADDR_W bits; the wrap from 63 to 0 is unreachable.
// CONFIGURATION
//   IRB_CKSUM_EN defined:
//   - cksum accumulates a 16-bit sum (mod 2^16, zero-extended pixels) of every pix_data accepted by a handshake.
//   - Cleared on reset; final once scan_done=1.
//   IRB_CKSUM_EN undefined: cksum tied to 16'h0000, no adder instantiated.
// TESTING
//   1. Write addr 0..63 with data=addr+8'h10 on consecutive cycles, done=1, pix_ready=1
//      -> wr_cnt=64; pixels 10h..4Fh in order; frame_end on the 64th; scan_done next cycle; no err_*.
//   2. Same frame, pix_ready toggled 1/0 every cycle -> each pixel held while ready=0; order and values unchanged.
//   3. Write addr 5 twice (AAh then 55h), others once, then done
//      -> err_dup=1, wr_cnt=64, pixel 5 = 55h.
//   4. Write only addrs 0..31, then done -> err_inc=1; pixels 32..63 read 00h.
//   5. Write during SCAN to addr 0 with FFh -> err_late=1; pixel 0 keeps its captured value.
//   6. Assert reset at pixel 20 of a scan -> all outputs 0 at once; a new full frame then replays correctly;
//      with IRB_CKSUM_EN, case 1 gives cksum=16'h0BE0.

Source files
------------

// File: rtl/lcd_irb_capture.sv
// ---------------------------------------------------------------------------
// lcd_irb_capture
//
// Image result buffer (IRB) model sitting downstream of the LCD controller.
// It captures the 64 pixel writes of the controller's write-back phase. Once
// the controller raises done, it replays the stored 8x8 frame in raster order
// over a valid/ready port. It also flags incomplete, duplicate and late writes.
//
// Optional feature macro: IRB_CKSUM_EN
//   defined   : cksum is a 16-bit running sum of every replayed pixel that was
//               accepted by a handshake.
//   undefined : cksum is tied to zero and no adder exists.
//
// Ports
//   clk        in   rising-edge clock shared with the controller
//   reset      in   asynchronous active-low reset (0 = reset)
//   IRB_RW     in   0 = write strobe this cycle, 1 or X = no write
//   IRB_A      in   write address (row = A[5:3], col = A[2:0])
//   IRB_D      in   write data
//   done       in   controller write-back complete (level)
//   pix_valid  out  replay pixel valid
//   pix_ready  in   replay consumer ready
//   pix_data   out  replay pixel value
//   pix_x      out  column of pix_data
//   pix_y      out  row of pix_data
//   frame_end  out  high together with the pixel at the last address
//   scan_done  out  sticky, set after the last replay handshake
//   wr_cnt     out  number of distinct addresses written
//   err_dup    out  sticky, an address was written twice while capturing
//   err_inc    out  sticky, done arrived before every address was written
//   err_late   out  sticky, write strobe seen after capture ended
//   cksum      out  replay checksum (zero unless IRB_CKSUM_EN)
//   dbg_state  out  current FSM state (0 CAPTURE, 1 SCAN, 2 HOLD)
//
// Replay handshake: a pixel transfers on every rising edge where pix_valid
// and pix_ready are both high. While pix_valid is high and pix_ready is low,
// pix_data, pix_x, pix_y and frame_end hold stable. pix_valid never drops
// without a transfer.
// ---------------------------------------------------------------------------
module lcd_irb_capture #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                IRB_RW,
    input  logic [ADDR_W-1:0]   IRB_A,
    input  logic [PIX_W-1:0]    IRB_D,
    input  logic                done,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [PIX_W-1:0]    pix_data,
    output logic [ADDR_W/2-1:0] pix_x,
    output logic [ADDR_W/2-1:0] pix_y,
    output logic                frame_end,
    output logic                scan_done,
    output logic [ADDR_W:0]     wr_cnt,
    output logic                err_dup,
    output logic                err_inc,
    output logic                err_late,
    output logic [15:0]         cksum,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HALF  = ADDR_W / 2;
    localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SCAN    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state;
    logic [PIX_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [ADDR_W-1:0] ptr;

    logic              wr_stb;
    logic              new_addr;
    logic [ADDR_W:0]   cnt_after;
    logic              handshake;
    logic [ADDR_W-1:0] nxt_ptr;
    logic [ADDR_W-1:0] fetch_a;
    logic [PIX_W-1:0]  fetch_d;

    assign dbg_state = state;

    // An X on IRB_RW compares to X and is treated as "no write".
    assign wr_stb    = (IRB_RW == 1'b0);
    assign new_addr  = wr_stb && !written[IRB_A];
    // Count including a write landing on the same edge as done.
    assign cnt_after = wr_cnt + {{ADDR_W{1'b0}}, new_addr};
    assign handshake = pix_valid && pix_ready;
    assign nxt_ptr   = ptr + 1'b1;

    // First presentation loads ptr; after a transfer the next address is
    // fetched on the same edge so a held-high ready sees no bubble.
    assign fetch_a = pix_valid ? nxt_ptr : ptr;
    assign fetch_d = written[fetch_a] ? mem[fetch_a] : '0;

    // Pixel storage: only writable while capturing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CAPTURE && wr_stb) begin
            mem[IRB_A] <= IRB_D;
        end
    end

    // Control FSM with registered replay outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CAPTURE;
            written   <= '0;
            wr_cnt    <= '0;
            ptr       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            frame_end <= 1'b0;
            scan_done <= 1'b0;
            err_dup   <= 1'b0;
            err_inc   <= 1'b0;
            err_late  <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (wr_stb) begin
                        written[IRB_A] <= 1'b1;
                        wr_cnt         <= cnt_after;
                        if (written[IRB_A]) begin
                            err_dup <= 1'b1;
                        end
                    end
                    if (done) begin
                        state <= SCAN;
                        ptr   <= '0;
                        if (cnt_after < FULL_CNT) begin
                            err_inc <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (wr_stb) begin
                        err_late <= 1'b1;
                    end
                    if (!pix_valid) begin
                        pix_valid <= 1'b1;
                        pix_data  <= fetch_d;
                        pix_x     <= fetch_a[HALF-1:0];
                        pix_y     <= fetch_a[ADDR_W-1:HALF];
                        frame_end <= (fetch_a == LAST_A);
                    end else if (pix_ready) begin
                        if (ptr == LAST_A) begin
                            pix_valid <= 1'b0;
                            frame_end <= 1'b0;
                            scan_done <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            ptr       <= nxt_ptr;
                            pix_data  <= fetch_d;
                            pix_x     <= fetch_a[HALF-1:0];
                            pix_y     <= fetch_a[ADDR_W-1:HALF];
                            frame_end <= (fetch_a == LAST_A);
                        end
                    end
                end
                HOLD: begin
                    if (wr_stb) begin
                        err_late <= 1'b1;
                    end
                end
                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

`ifdef IRB_CKSUM_EN
    // Zero-extended pixel sum, modulo 2^16, of accepted pixels only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum <= '0;
        end else if (handshake) begin
            cksum <= cksum + 16'(pix_data);
        end
    end
`else
    assign cksum = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_irb_capture.sv
// ---------------------------------------------------------------------------
// tb_lcd_irb_capture
//
// Directed bench for lcd_irb_capture. A frame model records every write the
// bench issues. When done is raised, the expected replay stream
// {frame_end, y, x, data} is pushed onto exp_q. Each pixel accepted by a
// handshake is popped and compared against the head of the queue.
// ---------------------------------------------------------------------------
module tb_lcd_irb_capture;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 6;
    localparam int W      = 15;

    logic              clk;
    logic              reset;
    logic              IRB_RW;
    logic [ADDR_W-1:0] IRB_A;
    logic [PIX_W-1:0]  IRB_D;
    logic              done;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic [2:0]        pix_x;
    logic [2:0]        pix_y;
    logic              frame_end;
    logic              scan_done;
    logic [ADDR_W:0]   wr_cnt;
    logic              err_dup;
    logic              err_inc;
    logic              err_late;
    logic [15:0]       cksum;
    logic [1:0]        dbg_state;

    lcd_irb_capture #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .IRB_RW    (IRB_RW),
        .IRB_A     (IRB_A),
        .IRB_D     (IRB_D),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_end (frame_end),
        .scan_done (scan_done),
        .wr_cnt    (wr_cnt),
        .err_dup   (err_dup),
        .err_inc   (err_inc),
        .err_late  (err_late),
        .cksum     (cksum),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   m_mem [64];
    bit           m_wr  [64];
    logic [15:0]  exp_sum;
    int           n_total;
    int           n_pass;

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cksum();
`ifdef IRB_CKSUM_EN
        return exp_sum;
`else
        return 16'h0000;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = 8'h00;
            m_wr[i]  = 1'b0;
        end
        exp_q.delete();
        exp_sum = 16'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_data"},  32'({pix_y, pix_x, pix_data}), 32'd0);
        check({tag, "_fend"},  32'({frame_end, scan_done}), 32'd0);
        check({tag, "_err"},   32'({err_dup, err_inc, err_late}), 32'd0);
        check({tag, "_cnt"},   32'(wr_cnt), 32'd0);
        check({tag, "_cksum"}, 32'(cksum), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_CAPTURE));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        IRB_RW    = 1'b1;
        done      = 1'b0;
        pix_ready = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Write strobe for one cycle; upd=0 leaves the model untouched (late writes).
    task automatic wr(input logic [5:0] a, input logic [7:0] d, input bit upd);
        @(negedge clk);
        IRB_RW = 1'b0;
        IRB_A  = a;
        IRB_D  = d;
        if (upd) begin
            m_mem[a] = d;
            m_wr[a]  = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        IRB_RW = 1'b1;
    endtask

    task automatic write_frame(input int mode);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = i[5:0];
            if (mode == 0) wr(a, 8'(a) + 8'h10, 1'b1);
            else           wr(a, 8'($urandom_range(0, 255)), 1'b1);
        end
        idle();
    endtask

    // Raise done for one edge and push the expected replay stream.
    // Returns at the negedge after done was sampled.
    task automatic start_scan();
        @(negedge clk);
        IRB_RW = 1'b1;
        done   = 1'b1;
        exp_sum = 16'h0;
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            logic [7:0] d;
            a = i[5:0];
            d = m_wr[i] ? m_mem[i] : 8'h00;
            exp_q.push_back({(a == 6'd63), a[5:3], a[2:0], d});
            exp_sum = exp_sum + {8'h00, d};
        end
        @(negedge clk);
        done = 1'b0;
        check("entry_valid", 32'(pix_valid), 32'd0);
        check("entry_state", 32'(dbg_state), 32'(ST_SCAN));
    endtask

    // mode 0: ready high, 1: ready toggles, 2: random ready.
    task automatic run_scan(input int mode, input int stop_after);
        int           hs;
        int           cyc;
        int           first_cyc;
        int           last_cyc;
        bit           hold_pending;
        logic [15:0]  held;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        hs = 0;
        cyc = 0;
        first_cyc = 0;
        last_cyc = 0;
        hold_pending = 1'b0;
        held = '0;
        while (hs < stop_after && cyc < 600) begin
            if (hold_pending) begin
                check("hold_stable", 32'({pix_valid, frame_end, pix_y, pix_x, pix_data}), 32'(held));
            end
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 2 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (pix_valid && pix_ready) begin
                got = {frame_end, pix_y, pix_x, pix_data};
                if (exp_q.size() == 0) begin
                    n_total = n_total + 1;
                    $error("FAIL q_underflow observed=%h expected=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("pixel", 32'(got), 32'(exp));
                end
                if (hs == 0) first_cyc = cyc;
                last_cyc = cyc;
                hs = hs + 1;
                hold_pending = 1'b0;
            end else if (pix_valid) begin
                hold_pending = 1'b1;
                held = {pix_valid, frame_end, pix_y, pix_x, pix_data};
            end
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("scan_handshakes", 32'(hs), 32'(stop_after));
        if (mode == 0 && stop_after == 64) begin
            check("no_bubble", 32'(last_cyc - first_cyc), 32'd63);
        end
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_valid_lo"}, 32'(pix_valid), 32'd0);
        check({tag, "_fend_lo"},  32'(frame_end), 32'd0);
        check({tag, "_scan_done"}, 32'(scan_done), 32'd1);
        check({tag, "_state"},    32'(dbg_state), 32'(ST_HOLD));
        check({tag, "_q_empty"},  32'(exp_q.size()), 32'd0);
        check({tag, "_cksum"},    32'(cksum), 32'(exp_cksum()));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b0;
        IRB_RW    = 1'b1;
        IRB_A     = '0;
        IRB_D     = '0;
        done      = 1'b0;
        pix_ready = 1'b0;
        model_clear();
        #12;
        check_all_zero("reset");
        reset = 1'b1;

        // Case 1: full ramp frame, ready held high.
        write_frame(0);
        check("c1_wr_cnt", 32'(wr_cnt), 32'd64);
        start_scan();
        @(negedge clk);
        check("c1_latency", 32'(pix_valid), 32'd1);
        run_scan(0, 64);
        end_checks("c1");
`ifdef IRB_CKSUM_EN
        check("c1_cksum_const", 32'(cksum), 32'h0BE0);
`endif
        check("c1_err", 32'({err_dup, err_inc, err_late}), 32'd0);
        // done in HOLD is ignored.
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("c1_hold_done", 32'({dbg_state, pix_valid}), 32'({ST_HOLD, 1'b0}));

        // Case 2: same frame, ready toggling.
        do_reset();
        write_frame(0);
        start_scan();
        run_scan(1, 64);
        end_checks("c2");

        // Case 3: address 5 written twice, the later data wins.
        do_reset();
        wr(6'd5, 8'hAA, 1'b1);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = i[5:0];
            wr(a, (a == 6'd5) ? 8'h55 : 8'(a) + 8'h10, 1'b1);
        end
        idle();
        check("c3_wr_cnt", 32'(wr_cnt), 32'd64);
        check("c3_err_dup", 32'(err_dup), 32'd1);
        start_scan();
        check("c3_err_inc", 32'(err_inc), 32'd0);
        run_scan(2, 64);
        end_checks("c3");

        // Case 4: half frame, then a late write in HOLD.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [5:0] a;
            a = i[5:0];
            wr(a, 8'(a) + 8'h10, 1'b1);
        end
        idle();
        check("c4_wr_cnt", 32'(wr_cnt), 32'd32);
        start_scan();
        check("c4_err_inc", 32'(err_inc), 32'd1);
        run_scan(0, 64);
        end_checks("c4");
        check("c4_late_before", 32'(err_late), 32'd0);
        wr(6'd3, 8'h77, 1'b0);
        idle();
        check("c4_late_hold", 32'(err_late), 32'd1);

        // Case 4b: last write and done on the same edge count as complete.
        do_reset();
        for (int i = 0; i < 63; i++) begin
            logic [5:0] a;
            a = i[5:0];
            wr(a, 8'(a), 1'b1);
        end
        wr(6'd63, 8'hC3, 1'b1);
        done = 1'b1;
        @(negedge clk);
        IRB_RW = 1'b1;
        done   = 1'b0;
        check("c4b_wr_cnt", 32'(wr_cnt), 32'd64);
        check("c4b_err_inc", 32'(err_inc), 32'd0);
        check("c4b_state", 32'(dbg_state), 32'(ST_SCAN));

        // Case 5: write during SCAN is flagged and ignored.
        do_reset();
        write_frame(0);
        start_scan();
        wr(6'd0, 8'hFF, 1'b0);
        idle();
        check("c5_err_late", 32'(err_late), 32'd1);
        check("c5_wr_cnt", 32'(wr_cnt), 32'd64);
        run_scan(0, 64);
        end_checks("c5");

        // Case 6: reset at pixel 20, then a fresh random frame.
        do_reset();
        write_frame(0);
        start_scan();
        run_scan(0, 20);
        check("c6_at20", 32'({pix_valid, pix_y, pix_x}), 32'({1'b1, 3'd2, 3'd4}));
        reset = 1'b0;
        #1;
        check_all_zero("c6_abort");
        model_clear();
        pix_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        write_frame(1);
        start_scan();
        run_scan(2, 64);
        end_checks("c6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
